mmul_stream_engine: RTL
=======================

MMUL_STREAM_ENGINE -- requirements
Module: mmul_stream_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each A and B element.
REQ-002 SHALL have parameter N, default 8: beats per dot product, N >= 2.
REQ-003 SHALL have parameter M, default 8: number of parallel MAC lanes.
REQ-004 SHALL have parameter ACC_WIDTH, default 3*DATA_WIDTH: accumulator width, ACC_WIDTH >= 2*DATA_WIDTH.
REQ-005 SHALL have parameter SIGNED, default 0: 1 means two's-complement operands, 0 means unsigned operands.
REQ-006 SHALL have parameter N_WIDTH, default $clog2(N): beat counter width.
REQ-007 SHALL have port i_clk, input, 1: the single clock.
REQ-008 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-009 SHALL have port i_clr, input, 1: synchronous clear.
REQ-010 SHALL have port i_a, input, DATA_WIDTH*M: one A element per lane, with lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port i_b, input, DATA_WIDTH: B element, broadcast to all lanes.
REQ-012 SHALL have ports i_valid (input, 1) and o_ready (output, 1): beat handshake.
REQ-013 SHALL have port o_c, output, ACC_WIDTH*M: lane i result at bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-014 SHALL have ports o_c_valid (output, 1) and i_c_ready (input, 1): result handshake.
REQ-015 SHALL have port o_overflow, output, M: sticky per-lane overflow flags.
REQ-016 SHALL have port o_busy, output, 1: high in any state other than IDLE.

Function
REQ-017 SHALL transfer a beat on a rising edge where i_valid, o_ready and !i_clr are all high.
REQ-018 SHALL implement states IDLE, ACCUM, DRAIN and OUT.
- IDLE: o_ready=1.
- ACCUM: o_ready=1.
- DRAIN: o_ready=0.
- OUT: o_ready=0, o_c_valid=1.
REQ-019 SHALL use these transitions:
- IDLE to ACCUM on the first beat.
- ACCUM to DRAIN on the Nth beat.
- DRAIN to OUT unconditionally.
- OUT to IDLE when i_c_ready=1.
REQ-020 SHALL register each lane's product a[i]*b on the edge that transfers the beat (stage 1).
REQ-021 SHALL add that product into the lane accumulator on the following edge (stage 2).
REQ-022 SHALL assert o_c_valid exactly 2 cycles after the cycle containing the Nth beat handshake.
REQ-023 SHALL drive o_c from the accumulators and hold it stable while o_c_valid=1 and i_c_ready=0.
REQ-024 SHALL zero the accumulators and o_overflow on the edge that leaves OUT, so the next vector starts clean.
REQ-025 SHALL form the 2*DATA_WIDTH product and extend it to ACC_WIDTH: sign-extend when SIGNED=1, zero-extend when SIGNED=0.
REQ-026 SHALL set o_overflow[i] sticky when the exact sum for lane i is outside the ACC_WIDTH range (signed or unsigned per SIGNED).
REQ-027 SHALL ignore i_valid while o_ready=0; no beat is lost or double-counted.
REQ-028 SHALL give i_clr priority over everything when high:
- next state IDLE;
- accumulators, stage-1 products, beat counter and o_overflow all cleared;
- no beat transfers in that cycle.
REQ-029 SHALL, when a beat transfers in the same cycle as i_c_ready in OUT, not occur, because o_ready=0 in OUT (no overlap of vectors).

Reset
REQ-030 SHALL, on i_rst_n low, asynchronously force:
- state IDLE;
- o_c = 0 and o_c_valid = 0;
- o_overflow = 0 and o_busy = 0;
- o_ready = 1;
- counter and stage-1 registers = 0.
REQ-031 SHALL abort any vector in progress, in any state, when reset is asserted.

Configuration
REQ-032 SHALL, with macro MMUL_ACC_SATURATE_EN defined, clamp an overflowing accumulator to the range limit:
- SIGNED=0: all-ones;
- SIGNED=1: max positive or min negative.
The sticky o_overflow flag still sets.
REQ-033 SHALL, without MMUL_ACC_SATURATE_EN, wrap modulo 2^ACC_WIDTH and set the o_overflow flag.

Structure
REQ-034 SHALL put the state enum typedef in shared package mmul_pkg.
REQ-035 SHALL put a saturation-limit helper function in mmul_pkg.
REQ-036 SHALL instantiate sub-module mmul_mac_lane M times; one instance holds one lane's product register, accumulator, overflow and saturation logic.
REQ-037 SHALL contain the FSM and beat counter at the top level.

Verification
REQ-038 Unsigned accumulate: defaults, a[i]=i+1, b=2 for all 8 beats -> o_c[i]=16*(i+1); o_c_valid rises exactly 2 cycles after the 8th handshake.
REQ-039 Back-pressure: hold i_c_ready=0 for 5 cycles in OUT with i_valid=1 -> o_ready=0, o_c unchanged, no beats counted; then i_c_ready=1 -> IDLE next cycle, and the next vector computes correctly.
REQ-040 Signed: SIGNED=1, a=0x80, b=0x7F for all beats -> every lane o_c = -130048 (24-bit 0xFE0400), o_overflow=0.
REQ-041 Overflow: ACC_WIDTH=16, SIGNED=0, a=b=0xFF for 8 beats ->
- without macro: o_c=0xF008, o_overflow all ones;
- with MMUL_ACC_SATURATE_EN: o_c=0xFFFF, o_overflow all ones.
REQ-042 Clear mid-vector: i_clr after 3 beats -> IDLE, o_c=0, o_overflow=0; the following full vector gives the exact expected sums.
REQ-043 Async reset: assert i_rst_n low in OUT between clock edges -> outputs reach reset values immediately; after release, o_ready=1 and o_c_valid=0.

Source files
------------

// File: rtl/mmul_pkg.sv
// Shared types and helpers for the streaming matrix-multiply engine.
// Holds the engine FSM state encoding and the accumulator clamp-value helper.
package mmul_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_e;

   localparam int SAT_MAX_WIDTH = 64;

   // Returns the clamp value for an accumulator of accWidth bits.
   // upper=1 gives the largest representable value, upper=0 the smallest
   // (all-ones / zero when unsigned, max positive / min negative when signed).
   // Callers truncate the result to their accumulator width.
   function automatic logic [SAT_MAX_WIDTH-1:0] satLimit(input int accWidth,
                                                         input logic isSigned,
                                                         input logic upper);
      logic [SAT_MAX_WIDTH-1:0] lim;
      lim = '0;
      for (int k = 0; k < SAT_MAX_WIDTH; k++) begin
         if (k < accWidth) begin
            if (isSigned && (k == accWidth - 1)) begin
               lim[k] = ~upper;
            end else begin
               lim[k] = upper;
            end
         end
      end
      return lim;
   endfunction

endpackage

// File: rtl/mmul_stream_engine_if.sv
// Bundle of the engine's beat and result handshake signals.
// master = the side feeding beats and consuming results, slave = the engine.
interface mmul_stream_engine_if #(
   parameter int DATA_WIDTH = 8,
   parameter int M          = 8,
   parameter int ACC_WIDTH  = 3*DATA_WIDTH
) ();

   logic                      clr;
   logic [DATA_WIDTH*M-1:0]   a;
   logic [DATA_WIDTH-1:0]     b;
   logic                      valid;
   logic                      ready;
   logic [ACC_WIDTH*M-1:0]    c;
   logic                      cValid;
   logic                      cReady;
   logic [M-1:0]              overflow;
   logic                      busy;

   modport master (
      output clr, a, b, valid, cReady,
      input  ready, c, cValid, overflow, busy
   );

   modport slave (
      input  clr, a, b, valid, cReady,
      output ready, c, cValid, overflow, busy
   );

endinterface

// File: rtl/mmul_mac_lane.sv
// One multiply-accumulate lane: product register (stage 1), accumulator
// (stage 2) and sticky overflow flag.
// Build option: define MMUL_ACC_SATURATE_EN to clamp an overflowing
// accumulator to its range limit instead of wrapping modulo 2^ACC_WIDTH.
module mmul_mac_lane
   import mmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24,
   parameter bit SIGNED     = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rstN_i,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic                  accum_i,
   input  logic                  zero_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [ACC_WIDTH-1:0]  acc_o,
   output logic                  overflow_o
);

   localparam int PROD_WIDTH = 2*DATA_WIDTH;

   logic [PROD_WIDTH-1:0] aExt;
   logic [PROD_WIDTH-1:0] bExt;
   logic [PROD_WIDTH-1:0] prodMul;
   logic [PROD_WIDTH-1:0] prod_q, prod_d;
   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                  ovf_q, ovf_d;
   logic [ACC_WIDTH-1:0]  prodExt;
   logic [ACC_WIDTH:0]    sumWide;
   logic [ACC_WIDTH-1:0]  sumFinal;
   logic                  sumOvf;

   // Full-width product; operands are sign-extended first when signed so the
   // low PROD_WIDTH bits are the exact two's-complement product.
   always_comb begin
      aExt    = {{DATA_WIDTH{SIGNED & a_i[DATA_WIDTH-1]}}, a_i};
      bExt    = {{DATA_WIDTH{SIGNED & b_i[DATA_WIDTH-1]}}, b_i};
      prodMul = aExt * bExt;
   end

   if (ACC_WIDTH > PROD_WIDTH) begin : gExt
      assign prodExt = {{(ACC_WIDTH-PROD_WIDTH){SIGNED & prod_q[PROD_WIDTH-1]}}, prod_q};
   end else begin : gNoExt
      assign prodExt = prod_q;
   end

   // Accumulate the registered product, detect range overflow and either
   // clamp or wrap the result.
   always_comb begin
      sumWide = {1'b0, acc_q} + {1'b0, prodExt};
      if (SIGNED) begin
         sumOvf = (acc_q[ACC_WIDTH-1] == prodExt[ACC_WIDTH-1]) &&
                  (sumWide[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
      end else begin
         sumOvf = sumWide[ACC_WIDTH];
      end
`ifdef MMUL_ACC_SATURATE_EN
      if (sumOvf) begin
         sumFinal = ACC_WIDTH'(satLimit(ACC_WIDTH, SIGNED,
                                        SIGNED ? ~acc_q[ACC_WIDTH-1] : 1'b1));
      end else begin
         sumFinal = sumWide[ACC_WIDTH-1:0];
      end
`else
      sumFinal = sumWide[ACC_WIDTH-1:0];
`endif
   end

   // Next-state for the lane: clear wins, then capture/accumulate/zero.
   always_comb begin
      prod_d = prod_q;
      acc_d  = acc_q;
      ovf_d  = ovf_q;
      if (clr_i) begin
         prod_d = '0;
         acc_d  = '0;
         ovf_d  = 1'b0;
      end else begin
         if (load_i) begin
            prod_d = prodMul;
         end
         if (zero_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
         end else if (accum_i) begin
            acc_d = sumFinal;
            ovf_d = ovf_q | sumOvf;
         end
      end
   end

   // Lane state registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rstN_i) begin
      if (!rstN_i) begin
         prod_q <= '0;
         acc_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         prod_q <= prod_d;
         acc_q  <= acc_d;
         ovf_q  <= ovf_d;
      end
   end

   assign acc_o      = acc_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/mmul_stream_engine.sv
// Streaming dot-product engine: M parallel MAC lanes share a broadcast B
// element; N beats form one vector, results are offered on a valid/ready
// handshake. The FSM and beat counter live here, per-lane math in
// mmul_mac_lane.
// Build option: MMUL_ACC_SATURATE_EN (accumulator saturation, see lane).
module mmul_stream_engine
   import mmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 8,
   parameter int M          = 8,
   parameter int ACC_WIDTH  = 3*DATA_WIDTH,
   parameter bit SIGNED     = 1'b0,
   parameter int N_WIDTH    = $clog2(N)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_clr,
   input  logic [DATA_WIDTH*M-1:0] i_a,
   input  logic [DATA_WIDTH-1:0]   i_b,
   input  logic                    i_valid,
   output logic                    o_ready,
   output logic [ACC_WIDTH*M-1:0]  o_c,
   output logic                    o_c_valid,
   input  logic                    i_c_ready,
   output logic [M-1:0]            o_overflow,
   output logic                    o_busy
);

   state_e             state_q, state_d;
   logic [N_WIDTH-1:0] beatCnt_q, beatCnt_d;
   logic               prodValid_q, prodValid_d;
   logic               readyInt;
   logic               beat;
   logic               lastBeat;
   logic               leaveOut;

   assign readyInt  = (state_q == IDLE) || (state_q == ACCUM);
   assign beat      = i_valid && readyInt && !i_clr;
   assign lastBeat  = (beatCnt_q == N_WIDTH'(N-1));
   assign leaveOut  = (state_q == OUT) && i_c_ready && !i_clr;

   assign o_ready   = readyInt;
   assign o_c_valid = (state_q == OUT);
   assign o_busy    = (state_q != IDLE);

   // Next-state logic; a synchronous clear always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (beat) state_d = ACCUM;
         ACCUM:   if (beat && lastBeat) state_d = DRAIN;
         DRAIN:   state_d = OUT;
         OUT:     if (i_c_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (i_clr) begin
         state_d = IDLE;
      end
   end

   // Beat counter and stage-1 valid tracking which product is still to be added.
   always_comb begin
      beatCnt_d   = beatCnt_q;
      prodValid_d = beat;
      if (i_clr) begin
         beatCnt_d   = '0;
         prodValid_d = 1'b0;
      end else if (beat) begin
         beatCnt_d = lastBeat ? '0 : beatCnt_q + 1'b1;
      end
   end

   // Control registers with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         beatCnt_q   <= '0;
         prodValid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         beatCnt_q   <= beatCnt_d;
         prodValid_q <= prodValid_d;
      end
   end

   for (genvar i = 0; i < M; i++) begin : gLane
      mmul_mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH),
         .SIGNED     (SIGNED)
      ) uLane (
         .clk_i      (i_clk),
         .rstN_i     (i_rst_n),
         .clr_i      (i_clr),
         .load_i     (beat),
         .accum_i    (prodValid_q),
         .zero_i     (leaveOut),
         .a_i        (i_a[i*DATA_WIDTH +: DATA_WIDTH]),
         .b_i        (i_b),
         .acc_o      (o_c[i*ACC_WIDTH +: ACC_WIDTH]),
         .overflow_o (o_overflow[i])
      );
   end

endmodule
